product_bcd_conv: RTL and testbench
===================================

PRODUCT_BCD_CONV -- requirements
Module: product_bcd_conv

Interface
REQ-001 Parameter: W, default 8, input product width in bits; legal range 4..9; the result always fits in 3 BCD digits (max 511).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
REQ-004 Port: in_valid  input  1  product on in_data is valid this cycle.
REQ-005 Port: in_data  input  W  unsigned binary product from the pipelined multiplier.
REQ-006 Port: in_ready  output  1  block can accept a product this cycle.
REQ-007 Port: out_valid  output  1  BCD result on the digit outputs is valid.
REQ-008 Port: out_ready  input  1  consumer (7-segment display driver) accepts the result.
REQ-009 Port: bcd_hun  output  4  hundreds digit, 0..5.
REQ-010 Port: bcd_ten  output  4  tens digit, 0..9.
REQ-011 Port: bcd_one  output  4  ones digit, 0..9.
REQ-012 Port: busy  output  1  conversion in progress (state SHIFT).

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 In IDLE: in_ready=1, out_valid=0, busy=0.
REQ-015 Accept = in_valid & in_ready at a rising edge; on accept, capture in_data into an internal shift register with a 12-bit BCD field cleared to zero, load the bit counter with W, and go to SHIFT.
REQ-016 Changes on in_data after the accept edge SHALL NOT affect the result.
REQ-017 In SHIFT: in_ready=0, busy=1. Each edge, add 3 to every BCD nibble >= 5, then shift the combined {BCD, binary} register left by 1, and decrement the counter (shift-add-3 / double dabble).
REQ-018 When the counter reaches 0 after exactly W shifts, register the BCD field onto bcd_hun/bcd_ten/bcd_one and go to DONE.
REQ-019 Latency: out_valid SHALL rise exactly W clock edges after the accept edge; 8 cycles for W=8.
REQ-020 In DONE: out_valid=1, in_ready=0, busy=0; the digit outputs SHALL hold stable until the handshake completes.
REQ-021 Handshake: out_valid & out_ready at an edge returns the FSM to IDLE; out_valid falls and in_ready rises after that edge.
REQ-022 With out_ready held high, the minimum spacing between accepts SHALL be W+2 cycles.
REQ-023 out_valid SHALL NOT depend combinationally on out_ready, and in_ready SHALL NOT depend combinationally on in_valid.
REQ-024 in_valid while in_ready=0 SHALL be ignored; no queuing.
REQ-025 The digit outputs SHALL update only on entry to DONE and retain the last result through IDLE and SHIFT.
REQ-026 Arithmetic: the result SHALL equal the decimal value of in_data for every input value 0..2^W-1; every digit nibble SHALL be <= 9 at all times.
REQ-027 An out_ready pulse in IDLE or SHIFT SHALL have no effect.

Reset
REQ-028 While rst_n=0 (asynchronous assertion): state=IDLE, in_ready=1 is permitted only after release; out_valid=0, busy=0, bcd_hun=bcd_ten=bcd_one=0, counter=0, shift register=0.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the conversion with no output update; the first accept is possible on the first edge after rst_n rises.

Verification
REQ-030 Reset, then in_data=8'd225 (15x15) with in_valid for one cycle and out_ready=1 -> out_valid rises 8 edges after accept, digits 2/2/5, high for 1 cycle.
REQ-031 in_data=0 -> digits 0/0/0 after 8 cycles; in_data=8'd99 -> 0/9/9; in_data=8'd255 -> 2/5/5.
REQ-032 Backpressure: 8'd144 accepted, out_ready=0 for 5 cycles after out_valid -> digits 1/4/4 stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge.
REQ-033 Reset mid-op: accept 8'd200, assert rst_n=0 during the 4th SHIFT cycle -> outputs 0/0/0 immediately; after release, accept 8'd37 -> 0/3/7.
REQ-034 Back-to-back: in_valid held high with in_data stepping 0..255 every cycle and out_ready=1 -> one accept every 10 cycles, each result matches the captured value, and every other in_data value is ignored.

Source files
------------

// File: rtl/product_bcd_conv.sv
// Purpose : binary product (W bits) to 3-digit BCD via shift-add-3 (double dabble).
// Latency : out_valid rises exactly W edges after the accept edge; accepts at most one product every W+2 cycles.
// Backpr. : holds the result in DONE with digits stable until out_ready; in_ready is low while SHIFT/DONE, no queuing.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     product handshake; in_data is the unsigned product (W bits, W in 4..9)
//   out_valid/out_ready   result handshake; bcd_hun/bcd_ten/bcd_one hold the last result
//   busy                  high while the conversion is shifting
module product_bcd_conv #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   bcd_hun,
  output logic [3:0]   bcd_ten,
  output logic [3:0]   bcd_one,
  output logic         busy
);

  // Combined {BCD[11:0], binary[W-1:0]} working register.
  localparam int SW = 12 + W;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] sreg;
  logic [SW-1:0] sreg_adj;
  logic [SW-1:0] sreg_shf;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          accept;

  assign accept   = in_valid & in_ready;
  assign cnt_last = (cnt == CW'(1));

  // Add 3 to every BCD nibble >= 5 so the following doubling carries
  // correctly into the next decimal digit.
  always_comb begin
    sreg_adj = sreg;
    for (int i = 0; i < 3; i++) begin
      if (sreg[W+4*i +: 4] >= 4'd5) begin
        sreg_adj[W+4*i +: 4] = sreg[W+4*i +: 4] + 4'd3;
      end
    end
    sreg_shf = sreg_adj << 1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs; all outputs decode from state only.
  // in_ready is held low during reset so nothing looks acceptable until release.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, shift W times, publish the BCD field on the
  // last shift so out_valid and the digits appear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      bcd_hun <= 4'd0;
      bcd_ten <= 4'd0;
      bcd_one <= 4'd0;
    end else begin
      if (state == IDLE) begin
        if (accept) begin
          sreg <= {12'd0, in_data};
          cnt  <= CW'(W);
        end
      end else if (state == SHIFT) begin
        sreg <= sreg_shf;
        cnt  <= cnt - CW'(1);
        if (cnt_last) begin
          bcd_hun <= sreg_shf[SW-1 -: 4];
          bcd_ten <= sreg_shf[SW-5 -: 4];
          bcd_one <= sreg_shf[SW-9 -: 4];
        end
      end
    end
  end

endmodule

// File: tb/tb_product_bcd_conv.sv
// Purpose : self-checking bench for product_bcd_conv against decimal arithmetic.
// Latency : expects out_valid W edges after accept and a W+2 cycle accept period.
// Backpr. : drives random out_ready holds; checks digits stay stable while stalled.
module tb_product_bcd_conv;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic         out_valid;
  logic [3:0]   bcd_hun;
  logic [3:0]   bcd_ten;
  logic [3:0]   bcd_one;
  logic         busy;

  int checks = 0;
  int errors = 0;

  product_bcd_conv #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bcd_hun  (bcd_hun),
    .bcd_ten  (bcd_ten),
    .bcd_one  (bcd_one),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Stimulus only (no comparisons). Called at a negedge; presents v for one
  // accept, injects random in_valid/in_data/out_ready noise while shifting,
  // holds out_ready low for 'hold' cycles in DONE, then completes the handshake.
  task automatic run_one(input logic [W-1:0] v, input int hold,
                         output int lat, output logic [11:0] dig,
                         output bit shift_ok, output bit stable_ok, output bit idle_after);
    in_valid  = 1'b1;
    in_data   = v;
    out_ready = 1'($urandom_range(0, 1));
    shift_ok  = 1'b1;
    stable_ok = 1'b1;
    lat       = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) shift_ok = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      lat++;
    end
    dig       = {bcd_hun, bcd_ten, bcd_one};
    out_ready = (hold == 0);
    in_valid  = 1'($urandom_range(0, 1));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 ||
          {bcd_hun, bcd_ten, bcd_one} !== dig) stable_ok = 1'b0;
      in_data  = W'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      if (k == hold - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    idle_after = (out_valid === 1'b0 && in_ready === 1'b1 && busy === 1'b0 &&
                  {bcd_hun, bcd_ten, bcd_one} === dig);
  endtask

  function automatic logic [11:0] dec3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || {bcd_hun, bcd_ten, bcd_one} !== 12'h000) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b busy=%b digits=%h required 0 0 000",
               out_valid, busy, {bcd_hun, bcd_ten, bcd_one});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_known;
    int          vals[4] = '{225, 0, 99, 255};
    int          lat;
    logic [11:0] dig;
    bit          sok, stk, idl;
    for (int i = 0; i < 4; i++) begin
      run_one(W'(vals[i]), 0, lat, dig, sok, stk, idl);
      checks++;
      if (dig !== dec3(vals[i]) || lat != W) begin
        errors++;
        $display("FAIL known_%0d: digits=%h lat=%0d required %h lat=%0d",
                 vals[i], dig, lat, dec3(vals[i]), W);
      end
      checks++;
      if (!sok || !idl) begin
        errors++;
        $display("FAIL known_hs_%0d: shift_ok=%b one_cycle_then_idle=%b required 1 1",
                 vals[i], sok, idl);
      end
    end
  endtask

  task automatic test_backpressure;
    int          lat;
    logic [11:0] dig;
    bit          sok, stk, idl;
    run_one(W'(144), 5, lat, dig, sok, stk, idl);
    checks++;
    if (dig !== 12'h144 || lat != W) begin
      errors++;
      $display("FAIL backpressure_val: digits=%h lat=%0d required 144 lat=%0d", dig, lat, W);
    end
    checks++;
    if (!stk || !idl) begin
      errors++;
      $display("FAIL backpressure_hold: stable=%b idle_after=%b required 1 1", stk, idl);
    end
  endtask

  task automatic test_reset_mid_op;
    int          lat;
    logic [11:0] dig;
    bit          sok, stk, idl;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = W'(200);
    @(negedge clk);              // 1st SHIFT cycle
    in_valid = 1'b0;
    repeat (3) @(negedge clk);   // 4th SHIFT cycle
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || {bcd_hun, bcd_ten, bcd_one} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_op: out_valid=%b busy=%b digits=%h required 0 0 000",
               out_valid, busy, {bcd_hun, bcd_ten, bcd_one});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_one(W'(37), 0, lat, dig, sok, stk, idl);
    checks++;
    if (dig !== 12'h037 || lat != W || !idl) begin
      errors++;
      $display("FAIL after_reset_37: digits=%h lat=%0d idle=%b required 037 lat=%0d idle=1",
               dig, lat, idl, W);
    end
  endtask

  // Every input value in shuffled order with random stall lengths.
  task automatic test_all_values;
    int          order[256];
    int          lat, tmp, j;
    logic [11:0] dig;
    bit          sok, stk, idl;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      run_one(W'(order[i]), $urandom_range(0, 2), lat, dig, sok, stk, idl);
      checks++;
      if (dig !== dec3(order[i]) || lat != W) begin
        errors++;
        $display("FAIL value_%0d: digits=%h lat=%0d required %h lat=%0d",
                 order[i], dig, lat, dec3(order[i]), W);
      end
      checks++;
      if (!sok || !stk || !idl) begin
        errors++;
        $display("FAIL value_hs_%0d: shift_ok=%b stable=%b idle=%b required 1 1 1",
                 order[i], sok, stk, idl);
      end
    end
  endtask

  // in_valid held high, in_data = cycle index; the accept period is W+2.
  task automatic test_back_to_back;
    logic [W-1:0] q[$];
    logic [W-1:0] v;
    bit           exp_rdy, exp_ov, exp_busy;
    @(negedge clk);
    out_ready = 1'b1;
    for (int c = 0; c < 260; c++) begin
      in_valid = (c < 256);
      in_data  = W'(c);
      exp_rdy  = (c % (W + 2) == 0);
      exp_ov   = (c % (W + 2) == W + 1);
      exp_busy = !exp_rdy && !exp_ov;
      checks++;
      if (in_ready !== exp_rdy || out_valid !== exp_ov || busy !== exp_busy) begin
        errors++;
        $display("FAIL b2b_ctrl c=%0d: rdy/ov/busy=%b%b%b required %b%b%b",
                 c, in_ready, out_valid, busy, exp_rdy, exp_ov, exp_busy);
      end
      checks++;
      if (bcd_hun > 4'd9 || bcd_ten > 4'd9 || bcd_one > 4'd9) begin
        errors++;
        $display("FAIL b2b_nibble c=%0d: digits=%h required each <= 9",
                 c, {bcd_hun, bcd_ten, bcd_one});
      end
      if (exp_rdy) q.push_back(W'(c));
      if (exp_ov && q.size() > 0) begin
        v = q.pop_front();
        checks++;
        if ({bcd_hun, bcd_ten, bcd_one} !== dec3(int'(v))) begin
          errors++;
          $display("FAIL b2b_val c=%0d: digits=%h required %h",
                   c, {bcd_hun, bcd_ten, bcd_one}, dec3(int'(v)));
        end
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d results outstanding required 0", q.size());
    end
  endtask

  initial begin
    test_reset;
    test_known;
    test_backpressure;
    test_reset_mid_op;
    test_all_values;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
